dcsr_debug_ctrl: RTL and testbench

- Owns the RISC-V debug control/status register (dcsr) and sequences debug-mode entry and exit for one hart.
- Arbitrates simultaneous halt sources by priority and records the winning cause and the interrupted privilege level.
- Runs the single-step state machine and drives the debug-mode, stop-counter and resume-privilege controls consumed by the core pipeline and the CSR file.

---
 rtl/dcsr_debug_ctrl_if.sv | 18 +
 rtl/dcsr_debug_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dcsr_debug_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcsr_debug_ctrl_if.sv
// dcsr access port between the CSR file (master) and the debug controller.
interface dcsr_debug_ctrl_if;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  modport master (
    output csr_wen,
    output csr_wdata,
    input  csr_rdata
  );

  modport slave (
    input  csr_wen,
    input  csr_wdata,
    output csr_rdata
  );
endinterface

// File: rtl/dcsr_debug_ctrl.sv
// RISC-V dcsr owner: halt arbitration, debug entry/exit and single-step.
// Halt sources are only sampled while running or stepping.
module dcsr_debug_ctrl #(
  parameter int unsigned XDEBUGVER = 4,
  parameter bit          HAS_S     = 1'b0,
  parameter bit          HAS_U     = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              cur_prv,
  input  logic                    haltreq,
  input  logic                    resethaltreq,
  input  logic                    trigger_hit,
  input  logic                    ebreak,
  input  logic                    insn_retire,
  input  logic                    exc_taken,
  input  logic                    dret,
  dcsr_debug_ctrl_if.slave        bus,
  output logic                    ebreak_to_debug,
  output logic                    debug_mode,
  output logic                    enter_debug,
  output logic                    exit_debug,
  output logic [1:0]              resume_prv,
  output logic                    stop_count,
  output logic                    stop_time
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DBG  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [3:0] XDV = XDEBUGVER[3:0];

  state_e      state_q, state_d;
  logic [1:0]  prv_q, prv_d;
  logic [2:0]  cause_q, cause_d;
  logic        step_q, step_d;
  logic        ebm_q, ebm_d;
  logic        ebs_q, ebs_d;
  logic        ebu_q, ebu_d;
  logic        scnt_q, scnt_d;
  logic        stim_q, stim_d;
  logic        enter_q, enter_d;
  logic        exit_q, exit_d;
  logic [1:0]  rprv_q, rprv_d;
  logic        first_q;

  logic        ebk_en;
  logic        ev_t, ev_e, ev_r, ev_h, ev_s;
  logic [2:0]  win;
  logic [1:0]  wprv;
  logic        wprv_ok;
  logic [31:0] wd;
  logic        unused_wdata;

  assign wd = bus.csr_wdata;
  assign unused_wdata = ^{wd[31:16], wd[14], wd[11], wd[8:3]};

  always_comb begin
    ebk_en = 1'b0;
    unique case (cur_prv)
      2'd3:    ebk_en = ebm_q;
      2'd1:    ebk_en = ebs_q;
      2'd0:    ebk_en = ebu_q;
      default: ebk_en = 1'b0;
    endcase
  end

  assign ebreak_to_debug = ebreak & ebk_en;

  assign ev_t = trigger_hit;
  assign ev_e = ebreak_to_debug;
  assign ev_r = resethaltreq & first_q;
  assign ev_h = haltreq;
  assign ev_s = (state_q == ST_STEP)
              & (insn_retire | exc_taken);

  always_comb begin
    win = 3'd0;
    priority case (1'b1)
      ev_t:    win = 3'd2;
      ev_e:    win = 3'd1;
      ev_r:    win = 3'd5;
      ev_h:    win = 3'd3;
      ev_s:    win = 3'd4;
      default: win = 3'd0;
    endcase
  end

  // prv is WARL: unsupported modes keep the old value
  assign wprv    = wd[1:0];
  assign wprv_ok = (wprv == 2'd3)
                 | ((wprv == 2'd1) & HAS_S)
                 | ((wprv == 2'd0) & HAS_U);

  always_comb begin
    state_d = state_q;
    prv_d   = prv_q;
    cause_d = cause_q;
    step_d  = step_q;
    ebm_d   = ebm_q;
    ebs_d   = ebs_q;
    ebu_d   = ebu_q;
    scnt_d  = scnt_q;
    stim_d  = stim_q;
    rprv_d  = rprv_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    unique case (state_q)
      ST_RUN, ST_STEP: begin
        if (win != 3'd0) begin
          state_d = ST_DBG;
          enter_d = 1'b1;
          cause_d = win;
          prv_d   = cur_prv;
        end
      end
      ST_DBG: begin
        if (dret) begin
          state_d = step_q ? ST_STEP : ST_RUN;
          exit_d  = 1'b1;
          rprv_d  = prv_q;
        end else if (bus.csr_wen) begin
          ebm_d  = wd[15];
          ebs_d  = HAS_S & wd[13];
          ebu_d  = HAS_U & wd[12];
          scnt_d = wd[10];
          stim_d = wd[9];
          step_d = wd[2];
          if (wprv_ok) prv_d = wprv;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      prv_q   <= 2'd3;
      cause_q <= 3'd0;
      step_q  <= 1'b0;
      ebm_q   <= 1'b0;
      ebs_q   <= 1'b0;
      ebu_q   <= 1'b0;
      scnt_q  <= 1'b0;
      stim_q  <= 1'b0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      rprv_q  <= 2'd3;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      prv_q   <= prv_d;
      cause_q <= cause_d;
      step_q  <= step_d;
      ebm_q   <= ebm_d;
      ebs_q   <= ebs_d;
      ebu_q   <= ebu_d;
      scnt_q  <= scnt_d;
      stim_q  <= stim_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      rprv_q  <= rprv_d;
      first_q <= 1'b0;
    end
  end

  assign debug_mode  = (state_q == ST_DBG);
  assign enter_debug = enter_q;
  assign exit_debug  = exit_q;
  assign resume_prv  = rprv_q;
  assign stop_count  = debug_mode & scnt_q;
  assign stop_time   = debug_mode & stim_q;

  assign bus.csr_rdata = {
    XDV, 12'd0,
    ebm_q, 1'b0, ebs_q, ebu_q,
    1'b0, scnt_q, stim_q,
    cause_q, 3'd0,
    step_q, prv_q
  };

endmodule

// File: tb/tb_dcsr_debug_ctrl.sv
// Bench for dcsr_debug_ctrl: cycle model compared every cycle,
// plus directed scenarios with literal dcsr expectations.
module tb_dcsr_debug_ctrl;

  localparam bit HAS_S = 1'b0;
  localparam bit HAS_U = 1'b1;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] cur_prv;
  logic       haltreq, resethaltreq, trigger_hit;
  logic       ebreak, insn_retire, exc_taken, dret;
  logic       ebreak_to_debug, debug_mode;
  logic       enter_debug, exit_debug;
  logic [1:0] resume_prv;
  logic       stop_count, stop_time;

  dcsr_debug_ctrl_if bus();

  dcsr_debug_ctrl #(
    .XDEBUGVER(4),
    .HAS_S(HAS_S),
    .HAS_U(HAS_U)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cur_prv(cur_prv),
    .haltreq(haltreq),
    .resethaltreq(resethaltreq),
    .trigger_hit(trigger_hit),
    .ebreak(ebreak),
    .insn_retire(insn_retire),
    .exc_taken(exc_taken),
    .dret(dret),
    .bus(bus),
    .ebreak_to_debug(ebreak_to_debug),
    .debug_mode(debug_mode),
    .enter_debug(enter_debug),
    .exit_debug(exit_debug),
    .resume_prv(resume_prv),
    .stop_count(stop_count),
    .stop_time(stop_time)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---- reference model ----
  bit       chk_en = 1'b0;
  bit       m_dbg, m_stepping, m_first;
  bit       m_ebm, m_ebs, m_ebu, m_sc, m_st, m_step;
  bit       m_enter, m_exit;
  bit [1:0] m_prv, m_resume;
  bit [2:0] m_cause;

  function automatic bit m_ebk();
    case (cur_prv)
      2'd3: return ebreak && m_ebm;
      2'd1: return ebreak && m_ebs;
      2'd0: return ebreak && m_ebu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [2:0] m_pick();
    bit       hit [5];
    int       code [5] = '{2, 1, 5, 3, 4};
    hit[0] = trigger_hit;
    hit[1] = m_ebk();
    hit[2] = m_first && resethaltreq;
    hit[3] = haltreq;
    hit[4] = m_stepping && (insn_retire || exc_taken);
    for (int i = 0; i < 5; i++)
      if (hit[i]) return 3'(code[i]);
    return 3'd0;
  endfunction

  function automatic logic [31:0] m_dcsr();
    logic [31:0] v = 32'h4000_0000;
    v[15]  = m_ebm;
    v[13]  = m_ebs;
    v[12]  = m_ebu;
    v[10]  = m_sc;
    v[9]   = m_st;
    v[8:6] = m_cause;
    v[2]   = m_step;
    v[1:0] = m_prv;
    return v;
  endfunction

  always @(posedge clock) begin
    bit [2:0]    cz;
    logic [31:0] w;
    chk_en = 1'b1;
    if (reset) begin
      m_dbg = 0; m_stepping = 0; m_first = 1;
      m_ebm = 0; m_ebs = 0; m_ebu = 0;
      m_sc = 0; m_st = 0; m_step = 0;
      m_enter = 0; m_exit = 0;
      m_prv = 2'd3; m_resume = 2'd3; m_cause = 0;
    end else begin
      cz = m_pick();
      m_enter = 0;
      m_exit = 0;
      if (!m_dbg) begin
        if (cz != 0) begin
          m_dbg = 1; m_stepping = 0; m_enter = 1;
          m_cause = cz; m_prv = cur_prv;
        end
      end else if (dret) begin
        m_dbg = 0; m_exit = 1;
        m_stepping = m_step;
        m_resume = m_prv;
      end else if (bus.csr_wen) begin
        w = bus.csr_wdata;
        m_ebm = w[15];
        m_ebs = HAS_S && w[13];
        m_ebu = HAS_U && w[12];
        m_sc = w[10]; m_st = w[9]; m_step = w[2];
        if (w[1:0] == 2'd3 ||
            (w[1:0] == 2'd1 && HAS_S) ||
            (w[1:0] == 2'd0 && HAS_U))
          m_prv = w[1:0];
      end
      m_first = 0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("rdata", bus.csr_rdata, m_dcsr());
      chk("dbg_mode", 32'(debug_mode), 32'(m_dbg));
      chk("enter", 32'(enter_debug), 32'(m_enter));
      chk("exit", 32'(exit_debug), 32'(m_exit));
      chk("resume", 32'(resume_prv), 32'(m_resume));
      chk("stopcnt", 32'(stop_count),
          32'(m_dbg && m_sc));
      chk("stoptim", 32'(stop_time),
          32'(m_dbg && m_st));
      chk("ebk2dbg", 32'(ebreak_to_debug),
          32'(m_ebk()));
    end
  end

  // ---- stimulus ----
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    haltreq = 0; trigger_hit = 0; ebreak = 0;
    insn_retire = 0; exc_taken = 0; dret = 0;
    bus.csr_wen = 0; bus.csr_wdata = 32'd0;
  endtask

  task automatic wr(input logic [31:0] v);
    bus.csr_wen = 1; bus.csr_wdata = v;
    tick();
    clr();
  endtask

  initial begin
    reset = 1; resethaltreq = 0; cur_prv = 2'd3;
    clr();
    tick(); tick();
    chk("L_rst_rdata", bus.csr_rdata, 32'h4000_0003);
    chk("L_rst_rprv", 32'(resume_prv), 32'd3);
    chk("L_rst_dbg", 32'(debug_mode), 32'd0);
    reset = 0;

    // ebreak disabled in M mode
    ebreak = 1;
    #1;
    chk("L_ebk_off", 32'(ebreak_to_debug), 32'd0);
    tick(); clr();
    chk("L_ebk_noent", 32'(debug_mode), 32'd0);

    // writes outside debug mode ignored
    wr(32'hFFFF_FFFF);
    chk("L_run_wr", bus.csr_rdata, 32'h4000_0003);

    haltreq = 1;
    tick(); clr();
    chk("L_h_enter", 32'(enter_debug), 32'd1);
    chk("L_h_rdata", bus.csr_rdata, 32'h4000_00C3);

    wr(32'hFFFF_FFFB);
    chk("L_wr_all", bus.csr_rdata, 32'h4000_96C3);
    chk("L_stopcnt", 32'(stop_count), 32'd1);
    wr(32'h0000_9602);
    chk("L_prv2", bus.csr_rdata, 32'h4000_96C3);
    wr(32'h0000_9601);
    chk("L_prv1", bus.csr_rdata, 32'h4000_96C3);

    // dret beats a same-cycle write
    dret = 1; bus.csr_wen = 1; bus.csr_wdata = 0;
    tick(); clr();
    chk("L_exit", 32'(exit_debug), 32'd1);
    chk("L_exit_rd", bus.csr_rdata, 32'h4000_96C3);

    trigger_hit = 1; haltreq = 1; ebreak = 1;
    tick(); clr();
    chk("L_prio", bus.csr_rdata, 32'h4000_9683);

    wr(32'h0000_9604);
    chk("L_step_wr", bus.csr_rdata, 32'h4000_9684);
    dret = 1;
    tick(); clr();
    cur_prv = 2'd0;
    chk("L_step_rprv", 32'(resume_prv), 32'd0);
    tick(); tick(); tick();
    chk("L_step_idle", 32'(debug_mode), 32'd0);
    insn_retire = 1;
    tick(); clr();
    chk("L_step_ent", bus.csr_rdata, 32'h4000_9704);

    dret = 1;
    tick(); clr();
    haltreq = 1; insn_retire = 1;
    tick(); clr();
    chk("L_step_pre", bus.csr_rdata, 32'h4000_96C4);

    wr(32'h0000_9600);
    dret = 1;
    tick(); clr();
    ebreak = 1;
    #1;
    chk("L_ebku_on", 32'(ebreak_to_debug), 32'd1);
    tick(); clr();
    chk("L_ebku_ent", bus.csr_rdata, 32'h4000_9640);

    // haltreq held across dret
    haltreq = 1; dret = 1;
    tick();
    dret = 0;
    chk("L_hd_exit", 32'(exit_debug), 32'd1);
    tick(); clr();
    chk("L_hd_enter", 32'(enter_debug), 32'd1);
    chk("L_hd_rd", bus.csr_rdata, 32'h4000_96C0);

    // reset while in debug
    reset = 1;
    tick();
    chk("L_rd_dbg", 32'(debug_mode), 32'd0);
    chk("L_rd_exit", 32'(exit_debug), 32'd0);
    chk("L_rd_rd", bus.csr_rdata, 32'h4000_0003);
    resethaltreq = 1;
    tick();
    reset = 0;
    tick();
    chk("L_rh_ent", 32'(enter_debug), 32'd1);
    chk("L_rh_rd", bus.csr_rdata, 32'h4000_0140);
    resethaltreq = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
